// File: rtl/fifo_8x8.sv
// rtl/fifo_8x8.sv - 8x8 synchronous FIFO with registered read port and sticky error flags
module fifo_8x8 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [3:0]        fifo_words,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [3:0]        count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Flags come straight from the registered count so they settle one cycle after an access.
  assign full  = (count_q == 4'(DEPTH));
  assign empty = (count_q == 4'd0);

  always_comb begin
    rd_acc      = rd_en & ~empty;
    wr_acc      = wr_en & (~full | rd_acc);
    wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 4'd1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 4'd1;
    end
    rd_data_d   = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d  = rd_acc;
    // A fresh error outranks clr_err in the same cycle.
    overflow_d  = (wr_en & ~wr_acc) | (overflow_q & ~clr_err);
    underflow_d = (rd_en & ~rd_acc) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; stale entries are never visible while the count says empty.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= fifo_data;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign fifo_words = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_8x8.sv
// tb/tb_fifo_8x8.sv - queue-model checker for fifo_8x8 with directed scenarios and random traffic
module tb_fifo_8x8;
  localparam int DEPTH = 8;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] fifo_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] fifo_words;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int errors = 0;
  int checks = 0;

  fifo_8x8 #(.DATA_W(8), .DEPTH(DEPTH), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .fifo_data(fifo_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_words(fifo_words), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated with the accept rules each rising edge.
  logic [7:0] mq[$];
  logic [7:0] m_rd_data;
  logic       m_rd_valid, m_ovf, m_unf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_rd_data = 8'h00; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      bit ra, wa;
      ra = rd_en && (mq.size() > 0);
      wa = wr_en && ((mq.size() < DEPTH) || ra);
      m_rd_valid = ra;
      if (ra) m_rd_data = mq.pop_front();
      if (wa) mq.push_back(fifo_data);
      m_ovf = (wr_en && !wa) || (m_ovf && !clr_err);
      m_unf = (rd_en && !ra) || (m_unf && !clr_err);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("words",     int'(fifo_words), mq.size());
      chk("full",      int'(full),       int'(mq.size() == DEPTH));
      chk("empty",     int'(empty),      int'(mq.size() == 0));
      chk("rd_valid",  int'(rd_valid),   int'(m_rd_valid));
      chk("rd_data",   int'(rd_data),    int'(m_rd_data));
      chk("overflow",  int'(overflow),   int'(m_ovf));
      chk("underflow", int'(underflow),  int'(m_unf));
      checks++;
      if (fifo_words > 4'd8) begin
        errors++;
        $display("FAIL words_bound: got %0d, expected at most 8", fifo_words);
      end
    end
  end

  logic [7:0] rlog[$];
  always @(negedge clk) if (rst_n && rd_valid) rlog.push_back(rd_data);

  // Inputs change just after a falling edge and are held for one full cycle.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
    wr_en = w; fifo_data = d; rd_en = r; clr_err = c;
    @(negedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_words"},  int'(fifo_words), 0);
    chk({tag, "_empty"},  int'(empty), 1);
    chk({tag, "_full"},   int'(full), 0);
    chk({tag, "_valid"},  int'(rd_valid), 0);
    chk({tag, "_data"},   int'(rd_data), 0);
    chk({tag, "_ovf"},    int'(overflow), 0);
    chk({tag, "_unf"},    int'(underflow), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; wr_en = 0; rd_en = 0; clr_err = 0; fifo_data = 8'h00;
    #1 chk_reset_vals("rst");
    @(negedge clk); #1; rst_n = 1'b1;

    // Five writes of 0xAA, then the producer's lagging sixth write.
    for (int i = 1; i <= 5; i++) begin
      step(1, 8'hAA, 0, 0);
      chk("aa_words", int'(fifo_words), i);
    end
    chk("aa_empty", int'(empty), 0);
    chk("aa_full", int'(full), 0);
    step(1, 8'hAA, 0, 0);
    chk("lag_words", int'(fifo_words), 6);
    chk("lag_ovf", int'(overflow), 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    rlog.delete();

    // Fill 0x01..0x08, then a rejected 0x09.
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
    step(1, 8'h09, 0, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_words", int'(fifo_words), 8);
    chk("fill_ovf", int'(overflow), 1);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);
    chk("drain_count", rlog.size(), 8);
    for (int i = 0; i < 8 && i < rlog.size(); i++) chk("drain_order", int'(rlog[i]), i + 1);
    rlog.delete();

    // Simultaneous read and write while full.
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'(8'h11 + i), 1, 0);
      chk("rw_full_words", int'(fifo_words), 8);
    end
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    begin
      logic [7:0] exp_seq [11];
      exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h11, 8'h12, 8'h13};
      chk("rw_count", rlog.size(), 11);
      for (int i = 0; i < 11 && i < rlog.size(); i++) chk("rw_order", int'(rlog[i]), int'(exp_seq[i]));
    end
    rlog.delete();

    // Read and write together while empty: only the write lands.
    step(1, 8'h55, 1, 0);
    chk("e_unf", int'(underflow), 1);
    chk("e_words", int'(fifo_words), 1);
    chk("e_valid", int'(rd_valid), 0);
    step(0, 8'h00, 1, 0);
    chk("e_valid2", int'(rd_valid), 1);
    chk("e_data", int'(rd_data), 8'h55);
    step(0, 8'h00, 0, 1);
    chk("clr_unf", int'(underflow), 0);
    chk("clr_ovf", int'(overflow), 0);
    step(0, 8'h00, 1, 1);
    chk("clr_prio_unf", int'(underflow), 1);
    step(0, 8'h00, 0, 1);

    // Streaming across the pointer wrap.
    rlog.delete();
    for (int i = 0; i < 20; i++) step(1, 8'(8'h30 + i), i >= 3, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("wrap_count", rlog.size(), 20);
    for (int i = 0; i < 20 && i < rlog.size(); i++) chk("wrap_order", int'(rlog[i]), 8'h30 + i);

    // Random traffic.
    n = 300;
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5, $urandom_range(0, 9) == 0);

    // Asynchronous reset between edges with words stored.
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + i), 0, 0);
    step(1, 8'hC4, 1, 0);
    wr_en = 0; rd_en = 0; clr_err = 0;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk); #1; rst_n = 1'b1;
    step(0, 8'h00, 1, 0);
    chk("post_rst_unf", int'(underflow), 1);
    chk("post_rst_valid", int'(rd_valid), 0);
    step(1, 8'h77, 0, 1);
    step(0, 8'h00, 1, 0);
    chk("post_rst_data", int'(rd_data), 8'h77);
    step(0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fifo_8x8.md
FIFO_8X8 -- requirements
Module: fifo_8x8

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, storage entries; legal values 2..15, power of two.
REQ-003 The block SHALL have parameter AW, default 3, pointer width, equal to log2(DEPTH).
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port wr_en  input  1  write request from the upstream producer FSM.
REQ-007 The block SHALL have port fifo_data  input  DATA_W  write data, sampled when wr_en=1.
REQ-008 The block SHALL have port rd_en  input  1  read request from the downstream consumer.
REQ-009 The block SHALL have port rd_data  output  DATA_W  registered read data.
REQ-010 The block SHALL have port rd_valid  output  1  one-cycle pulse; rd_data holds a newly read word.
REQ-011 The block SHALL have port fifo_words  output  4  current occupancy, 0..DEPTH.
REQ-012 The block SHALL have port full  output  1  high when fifo_words==DEPTH.
REQ-013 The block SHALL have port empty  output  1  high when fifo_words==0.
REQ-014 The block SHALL have port overflow  output  1  sticky flag: a write was rejected.
REQ-015 The block SHALL have port underflow  output  1  sticky flag: a read was rejected.
REQ-016 The block SHALL have port clr_err  input  1  synchronous clear of overflow and underflow.

Function
REQ-017 Write accept: wr_acc = wr_en & (~full | rd_acc); on wr_acc, mem[wr_ptr] <= fifo_data and wr_ptr advances by 1.
REQ-018 Read accept: rd_acc = rd_en & ~empty; no bypass, so a read when empty is rejected even with a simultaneous write.
REQ-019 On rd_acc, rd_data <= mem[rd_ptr] at the next edge, rd_ptr advances by 1, and rd_valid=1 for exactly that cycle.
REQ-020 Read latency: 1 cycle from rd_en to rd_valid/rd_data.
REQ-021 rd_data SHALL hold its last value when rd_valid=0.
REQ-022 Pointers: AW bits wide; wrap from DEPTH-1 to 0 with no extra state.
REQ-023 Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-024 fifo_words, full and empty SHALL be registered, or derived from the registered count only, and SHALL reflect an accepted access on the cycle after it.
REQ-025 Full with simultaneous wr_en and rd_en: both accepted, count stays DEPTH, ordering preserved (FIFO order, no reordering).
REQ-026 overflow SHALL set on wr_en & ~wr_acc; underflow SHALL set on rd_en & ~rd_acc.
REQ-027 A rejected access SHALL change no storage, pointer or count.
REQ-028 clr_err=1 SHALL clear both sticky flags at the next edge; a new error in the same cycle takes priority and sets its flag.
REQ-029 The block SHALL tolerate the producer's 1-cycle stop lag: a producer stopping at fifo_words==5 may issue one further write (6 words) without overflow at DEPTH=8.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of clk, force: wr_ptr=0, rd_ptr=0, count=0, fifo_words=0, empty=1, full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-031 Memory contents SHALL NOT be reset; they are unobservable while empty.
REQ-032 Reset asserted mid-operation SHALL discard all stored words; the first read after release returns the first word written after release.
REQ-033 Deassertion SHALL be synchronous to clk (external synchronizer); the first access is accepted on the first edge with rst_n=1.

Verification
REQ-034 Scenario: reset, then write 0xAA x5 -> fifo_words steps 1..5, empty=0, full=0.
REQ-035 Scenario: write 0x01..0x08, then wr_en with 0x09 -> full=1, fifo_words=8, overflow=1, 0x09 never read; 8 reads return 0x01..0x08 in order, each rd_valid 1 cycle after rd_en.
REQ-036 Scenario: at full, wr_en=rd_en=1 for 3 cycles -> count stays 8, reads return 0x01,0x02,0x03, writes stored after 0x08.
REQ-037 Scenario: empty, rd_en=1 and wr_en=1 (0x55) -> read rejected, underflow=1, fifo_words=1; next read returns 0x55; clr_err -> flags 0.
REQ-038 Scenario: stream 20 writes/reads across pointer wrap -> data order intact and fifo_words never exceeds 8.
REQ-039 Scenario: rst_n low between edges with 4 words stored -> outputs reach reset values before the next edge; post-reset read rejected (underflow=1).
